// File: rtl/up_frame_distributor.sv
// Purpose: spreads whole AXI-Stream frames from one source across M_COUNT output ports, round robin over port_enable.
// Latency: one idle bubble cycle before each frame, then zero-cycle combinational pass-through of every beat.
// Backpressure: s_axis_tready follows m_axis_tready of the selected port; readiness of other ports is ignored.
//
// Ports:
//   clk, rst                  single clock; synchronous active-low reset
//   s_axis_*                  upstream frame source (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_*                  M_COUNT output streams, port i in slice i of each bus
//   port_enable               per-port eligibility mask, sampled only when a frame is about to start
//   frame_count, drop_count   wrapping statistics: frames completed per port, frames dropped
module up_frame_distributor #(
    parameter int M_COUNT         = 3,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int CNT_WIDTH       = 32,
    parameter int SEL_WIDTH       = $clog2(M_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]                   m_axis_tvalid,
    input  logic [M_COUNT-1:0]                   m_axis_tready,
    output logic [M_COUNT-1:0]                   m_axis_tlast,
    input  logic [M_COUNT-1:0]                   port_enable,
    output logic [M_COUNT*CNT_WIDTH-1:0]         frame_count,
    output logic [CNT_WIDTH-1:0]                 drop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] sel;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_found;
    logic [SEL_WIDTH:0]   cand;
    logic                 fwd_last;
    logic                 drop_last;
    logic [CNT_WIDTH-1:0] drop_cnt;

    // Round-robin search: first enabled port at or after rr_ptr, wrapping.
    // cand is one bit wider so rr_ptr + i (< 2*M_COUNT) never overflows before the wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            cand = {1'b0, rr_ptr} + (SEL_WIDTH + 1)'(i);
            if (cand >= (SEL_WIDTH + 1)'(M_COUNT)) begin
                cand = cand - (SEL_WIDTH + 1)'(M_COUNT);
            end
            if (!pick_found && port_enable[cand[SEL_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SEL_WIDTH-1:0];
            end
        end
    end

    // Payload is broadcast to every slice; only tvalid qualifies the selected port.
    assign m_axis_tdata = {M_COUNT{s_axis_tdata}};
    assign m_axis_tkeep = {M_COUNT{s_axis_tkeep}};
    assign m_axis_tlast = {M_COUNT{s_axis_tlast}};

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;
        fwd_last      = 1'b0;
        drop_last     = 1'b0;
        case (state)
            IDLE: begin
                // Bubble cycle: nothing is accepted while the destination is chosen.
                if (s_axis_tvalid) begin
                    state_nxt = pick_found ? FORWARD : DROP;
                end
            end
            FORWARD: begin
                s_axis_tready      = m_axis_tready[sel];
                m_axis_tvalid[sel] = s_axis_tvalid;
                if (s_axis_tvalid && m_axis_tready[sel] && s_axis_tlast) begin
                    fwd_last  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sel is latched only at frame start, so mask changes mid-frame cannot move a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= '0;
            sel      <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == IDLE && s_axis_tvalid && pick_found) begin
                sel <= pick_idx;
            end
            if (fwd_last) begin
                rr_ptr <= (sel == SEL_WIDTH'(M_COUNT - 1)) ? '0 : sel + SEL_WIDTH'(1);
            end
            if (drop_last) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign drop_count = drop_cnt;

    for (genvar g = 0; g < M_COUNT; g++) begin : g_frame_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (fwd_last && sel == SEL_WIDTH'(g)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end

        assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

endmodule
